// File: rtl/counter_cmd_gen.sv
// Command front end for the 4-bit up/down counter: debounced step buttons with
// hold-to-repeat, and a handshaked limit load that never overlaps a step.
module counter_cmd_gen #(
  parameter int         DEB_CYCLES    = 4,
  parameter int         REPEAT_CYCLES = 8,
  parameter logic [3:0] INIT_MAX      = 4'hF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_inc_raw,
  input  logic       btn_dec_raw,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_data,
  output logic       cfg_ready,
  output logic [3:0] count_to,
  output logic       count_inc,
  output logic       count_dec,
  output logic       load_en
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);
  localparam bit         REP_EN   = (REPEAT_CYCLES != 0);

  // Bit 0 is the increment button, bit 1 the decrement button.
  logic [1:0]      sync_q, s, db, db_q;
  logic [1:0][3:0] deb_cnt;
  logic [7:0]      rep_cnt;
  logic [1:0]      rise;
  logic            only_inc, only_dec, rep_run, rep_hit, fire_inc, fire_dec;

  logic [1:0] state, state_nxt;
  logic [3:0] count_to_nxt;
  logic       load_nxt, ready_nxt, idle_nxt;

  // NOTE: flops use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      s       <= '0;
      db      <= '0;
      db_q    <= '0;
      deb_cnt <= '0;
    end else begin
      sync_q <= {btn_dec_raw, btn_inc_raw};
      s      <= sync_q;
      db_q   <= db;
      for (int i = 0; i < 2; i++) begin
        if (s[i] != db[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            db[i]      <= s[i];
            deb_cnt[i] <= 4'd0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 4'd1;
          end
        end else begin
          deb_cnt[i] <= 4'd0;
        end
      end
    end
  end

  always_comb begin
    rise     = db & ~db_q;
    only_inc = db[0] & ~db[1];
    only_dec = db[1] & ~db[0];
    rep_run  = REP_EN && (only_inc || only_dec);
    rep_hit  = REP_EN && (rep_cnt == REP_LAST);
    fire_inc = only_inc & (rise[0] | rep_hit);
    fire_dec = only_dec & (rise[1] | rep_hit);
  end

  // The schedule restarts on every candidate pulse, even one the FSM drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= 8'd0;
    end else if (rep_run && !(fire_inc || fire_dec)) begin
      rep_cnt <= rep_cnt + 8'd1;
    end else begin
      rep_cnt <= 8'd0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    count_to_nxt = count_to;
    ready_nxt    = cfg_ready;
    load_nxt     = 1'b0;
    case (state)
      ST_INIT: begin
        count_to_nxt = INIT_MAX;
        load_nxt     = 1'b1;
        state_nxt    = ST_LOAD;
      end
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (cfg_valid && cfg_ready) begin
          count_to_nxt = cfg_data;
          ready_nxt    = 1'b0;
          state_nxt    = ST_LOAD;
        end
      end
      // A handshake-driven load gives count_to one setup cycle before the strobe.
      ST_LOAD: begin
        if (!load_en) begin
          load_nxt = 1'b1;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
    idle_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      count_to  <= 4'd0;
      cfg_ready <= 1'b0;
      load_en   <= 1'b0;
      count_inc <= 1'b0;
      count_dec <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_to  <= count_to_nxt;
      cfg_ready <= ready_nxt;
      load_en   <= load_nxt;
      count_inc <= fire_inc & idle_nxt;
      count_dec <= fire_dec & idle_nxt;
    end
  end

endmodule

// File: tb/tb_counter_cmd_gen.sv
// Directed bench for counter_cmd_gen: a scoreboard of expected step pulses
// (cycle and direction) plus direct checks of the load sequencing.
module tb_counter_cmd_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_inc_raw = 1'b0;
  logic       btn_dec_raw = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_data = 4'd0;

  logic       cfg_ready, count_inc, count_dec, load_en;
  logic [3:0] count_to;
  logic       nr_cfg_ready, nr_count_inc, nr_count_dec, nr_load_en;
  logic [3:0] nr_count_to;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] nr_q[$];
  logic [31:0] mon_exp, nr_exp;

  localparam logic [1:0] K_INC = 2'b10;
  localparam logic [1:0] K_DEC = 2'b01;

  counter_cmd_gen #(.DEB_CYCLES(4), .REPEAT_CYCLES(8), .INIT_MAX(4'hF)) u_dut (
    .clk(clk), .reset_n(reset_n), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .count_to(count_to),
    .count_inc(count_inc), .count_dec(count_dec), .load_en(load_en)
  );

  counter_cmd_gen #(.DEB_CYCLES(4), .REPEAT_CYCLES(0), .INIT_MAX(4'hF)) u_norep (
    .clk(clk), .reset_n(reset_n), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(nr_cfg_ready), .count_to(nr_count_to),
    .count_inc(nr_count_inc), .count_dec(nr_count_dec), .load_en(nr_load_en)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release: after edge Ek, cyc == k.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int c, input logic [1:0] kind);
    return {c[29:0], kind};
  endfunction

  // Each observed pulse must match the oldest expected {cycle, direction}.
  always @(negedge clk) begin
    if (reset_n && (count_inc || count_dec)) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("dut_pulse", {cyc[29:0], count_inc, count_dec}, mon_exp);
    end
    if (reset_n && (nr_count_inc || nr_count_dec)) begin
      nr_exp = (nr_q.size() != 0) ? nr_q.pop_front() : 32'hFFFF_FFFF;
      check("norep_pulse", {cyc[29:0], nr_count_inc, nr_count_dec}, nr_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_count_to"},  32'(count_to),  32'h0);
    check({tag, "_load_en"},   32'(load_en),   32'h0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'h0);
    check({tag, "_steps"},     32'({count_inc, count_dec, nr_count_inc, nr_count_dec}), 32'h0);
  endtask

  task automatic init_seq(input string tag);
    reset_n = 1'b1;
    tick(1);
    check({tag, "_e1_count_to"}, 32'(count_to),    32'hF);
    check({tag, "_e1_load_en"},  32'(load_en),     32'h1);
    check({tag, "_e1_ready"},    32'(cfg_ready),   32'h0);
    check({tag, "_e1_nr_load"},  32'(nr_load_en),  32'h1);
    tick(1);
    check({tag, "_e2_load_en"},  32'(load_en),     32'h0);
    check({tag, "_e2_ready"},    32'(cfg_ready),   32'h0);
    tick(1);
    check({tag, "_e3_ready"},    32'(cfg_ready),   32'h1);
    check({tag, "_e3_nr_ready"}, 32'(nr_cfg_ready), 32'h1);
    check({tag, "_e3_count_to"}, 32'(nr_count_to), 32'hF);
  endtask

  task automatic drained(input string tag);
    check({tag, "_dut_pending"},   32'(exp_q.size()), 32'h0);
    check({tag, "_norep_pending"}, 32'(nr_q.size()),  32'h0);
  endtask

  initial begin
    int k;

    // Reset then idle.
    tick(3);
    reset_checks("reset");
    init_seq("init");
    tick(50);
    drained("idle");

    // Clean press held 20 cycles: first sample at k+1, db rises at k+6, pulse after k+7;
    // repeats every 8 while db is high (db falls at k+26).
    k = cyc;
    btn_inc_raw = 1'b1;
    exp_q.push_back(ev(k + 7, K_INC));
    exp_q.push_back(ev(k + 15, K_INC));
    exp_q.push_back(ev(k + 23, K_INC));
    nr_q.push_back(ev(k + 7, K_INC));
    tick(20);
    btn_inc_raw = 1'b0;
    tick(15);
    drained("press");

    // Glitch of 3 samples on dec: rejected.
    btn_dec_raw = 1'b1;
    tick(3);
    btn_dec_raw = 1'b0;
    tick(15);
    drained("glitch");

    // Repeat, then dec pressed mid-hold (db_dec rises at k+26): repeats stop, no dec pulse.
    k = cyc;
    btn_inc_raw = 1'b1;
    exp_q.push_back(ev(k + 7, K_INC));
    exp_q.push_back(ev(k + 15, K_INC));
    exp_q.push_back(ev(k + 23, K_INC));
    nr_q.push_back(ev(k + 7, K_INC));
    tick(20);
    btn_dec_raw = 1'b1;
    tick(20);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(15);
    drained("repeat_dec");

    // Config under traffic: accepted on edge k+14; the repeat due at k+15 is dropped.
    k = cyc;
    btn_inc_raw = 1'b1;
    exp_q.push_back(ev(k + 7, K_INC));
    exp_q.push_back(ev(k + 23, K_INC));
    exp_q.push_back(ev(k + 31, K_INC));
    nr_q.push_back(ev(k + 7, K_INC));
    tick(13);
    cfg_valid = 1'b1;
    cfg_data  = 4'd7;
    tick(1);
    check("cfg_e0_count_to", 32'(count_to),  32'h7);
    check("cfg_e0_ready",    32'(cfg_ready), 32'h0);
    check("cfg_e0_load_en",  32'(load_en),   32'h0);
    cfg_data = 4'd3;
    tick(1);
    check("cfg_e1_load_en",  32'(load_en),   32'h1);
    check("cfg_e1_ready",    32'(cfg_ready), 32'h0);
    check("cfg_e1_inc_drop", 32'(count_inc), 32'h0);
    tick(1);
    check("cfg_e2_load_en",  32'(load_en),   32'h0);
    check("cfg_e2_ready",    32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    tick(1);
    check("cfg_e3_ready",    32'(cfg_ready), 32'h1);
    check("cfg_e3_count_to", 32'(count_to),  32'h7);
    check("cfg_e3_load_en",  32'(load_en),   32'h0);
    tick(13);
    btn_inc_raw = 1'b0;
    tick(15);
    check("cfg_hold_count_to", 32'(count_to), 32'h7);
    drained("cfg");

    // Async reset during the load strobe clears outputs without a clock edge.
    cfg_valid = 1'b1;
    cfg_data  = 4'd5;
    tick(1);
    cfg_valid = 1'b0;
    check("rst_accept_count_to", 32'(count_to), 32'h5);
    tick(1);
    check("rst_pre_load_en", 32'(load_en), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    reset_checks("async");
    tick(2);
    reset_checks("async_held");
    init_seq("reinit");
    tick(20);
    drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
